mem_arbiter: RTL

//  Round-robin arbiter and access sequencer that shares one Memory (re/we/addr, tri-state data) among

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/bus_driver.sv | 12 +
 rtl/mem_arbiter_rr_picker.sv | 27 ++
 rtl/mem_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter slice.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t;

endpackage

// File: rtl/bus_driver.sv
// Tri-state driver cell used to put a value on a shared bidirectional bus.
module BusDriver #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic [W-1:0] d,
  inout  wire  [W-1:0] bus
);

  assign bus = en ? d : {W{1'bz}};

endmodule

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin selector: first asserted request after the previous winner, wrapping around.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            found,
  output logic [IW-1:0]   winner
);

  logic [IW-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last) + i) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port among NREQ requesters: round-robin pick in IDLE, one bus access in ACCESS.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 16,
  parameter int AW   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ-1:0][AW-1:0]   req_addr,
  input  logic [NREQ-1:0][DW-1:0]   req_wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           rvalid,
  output logic [DW-1:0]             rdata,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  inout  wire  [DW-1:0]             mem_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t    state;
  logic [IW-1:0] win;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic          found;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [NREQ-1:0] win_onehot;
  logic          in_access;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req    (req),
    .last   (last),
    .found  (found),
    .winner (pick)
  );

  assign win_onehot = NREQ'(1) << win;

  // Winner's operation is captured so requester changes during ACCESS cannot disturb it
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB_IDLE;
      win       <= '0;
      last      <= IW'(NREQ - 1);
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rvalid    <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          rvalid <= '0;
          if (found) begin
            win       <= pick;
            last      <= pick;
            lat_we    <= req_we[pick];
            lat_addr  <= req_addr[pick];
            lat_wdata <= req_wdata[pick];
            state     <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          state <= ARB_IDLE;
          if (!lat_we) begin
            rdata  <= mem_data;
            rvalid <= win_onehot;
          end else begin
            rvalid <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign in_access = (state == ARB_ACCESS);
  assign gnt       = in_access ? win_onehot : '0;
  assign mem_we    = in_access && lat_we;
  assign mem_re    = in_access && !lat_we;
  assign mem_addr  = in_access ? lat_addr : '0;

  BusDriver #(.W(DW)) u_bus_driver (
    .en  (mem_we),
    .d   (lat_wdata),
    .bus (mem_data)
  );

endmodule
